pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Parametrised program-counter generator for the in-order pipeline's fetch stage.
- Provides the fetch address and instruction-memory chip enable.
- Beyond plain sequential increment, it also handles:
  - a configurable reset vector;
  - flush redirects (exception/eret) and branch redirects;
  - a one-entry pending-redirect buffer, so a branch resolved during a fetch stall is not lost;
  - a misaligned-PC flag.

Parameters:
- ADDR_W, 32, width of pc and all target buses.
- RESET_VEC, 32'h0000_0000, pc value held during and immediately after reset.
- INC_BYTES, 4, sequential increment per advance.
- STALL_W, 6, width of the pipeline stall vector; bit 0 is the fetch stage.
- ALIGN_LOG2, 2, pc low bits that must be zero (0 disables the check).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  STALL_W  stall vector; only stall[0] affects this block (1 = hold).
- flush  in  1  exception/eret redirect request.
- flush_pc  in  ADDR_W  flush target.
- branch_flag  in  1  branch/jump taken, resolved in decode.
- branch_target  in  ADDR_W  branch target.
- ce  out  1  instruction-memory chip enable.
- pc  out  ADDR_W  current fetch address.
- redirect_pending  out  1  a branch target is buffered awaiting stall release.
- misaligned  out  1  current pc violates ALIGN_LOG2 alignment.

Behaviour:
- Reset (rst=1 at an edge) sets:
  - ce=0, pc=RESET_VEC, redirect_pending=0, buffered target=0;
  - misaligned = alignment check of RESET_VEC.
- Reset mid-operation discards any pending redirect.
- ce is a register loaded with !rst. It rises the first edge after rst deasserts.
- While ce=0 (registered value), pc holds RESET_VEC and all inputs are ignored. The first increment occurs on the edge after ce becomes 1, so RESET_VEC is presented with ce=1 for at least one cycle.
- With ce=1, the next pc is chosen by strict priority:
  1. flush=1: pc <= flush_pc, regardless of stall[0]. Clears pending, including any simultaneous branch_flag.
  2. branch_flag=1 and stall[0]=0: pc <= branch_target; clears pending.
  3. branch_flag=1 and stall[0]=1: pc holds. The target is captured into the buffer and pending <= 1. A newer branch overwrites an older buffered target (latest wins).
  4. pending=1 and stall[0]=0: pc <= buffered target; pending <= 0.
  5. pending=1 and stall[0]=1: pc holds; buffer holds.
  6. stall[0]=1: pc holds.
  7. Otherwise: pc <= pc + INC_BYTES, modulo 2^ADDR_W. ADDR_W'hFFFF_FFFC + 4 wraps to 0 with no flag.
- Latency: every redirect is visible on pc the edge after the request (one cycle). A buffered redirect is visible the edge after stall[0] falls.
- redirect_pending is the registered pending bit, asserted the cycle after capture.
- misaligned is registered with pc, computed from the value being loaded: 1 if any of its low ALIGN_LOG2 bits are nonzero. Constant 0 when ALIGN_LOG2=0.
  - The pc is still loaded as given; downstream raises the exception.
- stall[STALL_W-1:1] are unused here and have no effect.

Test Plan:
- Reset/startup: hold rst 3 cycles, then release with RESET_VEC=32'hBFC0_0000.
  - ce=0, pc=BFC00000 during rst.
  - ce=1 one edge after release, pc still BFC00000.
  - Following edges give BFC00004, BFC00008.
- Stall hold and wrap:
  - Load pc=FFFFFFF8 via flush, then stall[0]=1 for 2 cycles: pc stays FFFFFFF8.
  - Release: pc goes FFFFFFFC, then 00000000.
- Branch during stall:
  - stall[0]=1, branch_flag=1 target=00001000 for one cycle: pc unchanged, redirect_pending=1.
  - Second branch to 00002000 while still stalled: pending target becomes 00002000.
  - Drop stall: next pc=00002000, redirect_pending=0, then 00002004.
- Priority collisions:
  - flush=1 (flush_pc=80000180) with branch_flag=1 and stall[0]=1 in the same cycle: pc=80000180, redirect_pending=0.
  - Pending set, then flush: pending cleared and flush_pc taken.
- Misalignment: branch to 00000102 gives pc=00000102, misaligned=1. Next increment gives 00000106, misaligned=1. Flush to 00000200 gives misaligned=0.
- Reset mid-pending: with redirect_pending=1, assert rst for one cycle. Required: ce=0, pc=RESET_VEC, redirect_pending=0, and the buffered target is never applied after restart.

Source files
------------

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch-stage program counter with flush/branch redirect and one-entry redirect buffer
// Priority: flush > branch > buffered branch > stall > sequential increment.
module pc_gen #(
  parameter int unsigned ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = 32'h0000_0000,
  parameter int unsigned INC_BYTES  = 4,
  parameter int unsigned STALL_W    = 6,
  parameter int unsigned ALIGN_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STALL_W-1:0] stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              ce,
  output logic [ADDR_W-1:0] pc,
  output logic              redirect_pending,
  output logic              misaligned
);

  localparam logic [ADDR_W-1:0] INC = ADDR_W'(INC_BYTES);
  // Mask collapses to zero when ALIGN_LOG2 is 0, which disables the check.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((64'd1 << ALIGN_LOG2) - 64'd1);

  logic              ce_q;
  logic [ADDR_W-1:0] pc_q;
  logic              pend_q;
  logic [ADDR_W-1:0] tgt_q;
  logic              mis_q;

  logic [ADDR_W-1:0] pc_nxt;
  logic              pend_nxt;
  logic [ADDR_W-1:0] tgt_nxt;
  logic              mis_nxt;
  logic              stall_fetch;

  logic unused_stall;
  assign unused_stall = ^stall[STALL_W-1:1];
  assign stall_fetch  = stall[0];

  always_comb begin
    pc_nxt   = pc_q;
    pend_nxt = pend_q;
    tgt_nxt  = tgt_q;
    if (ce_q) begin
      if (flush) begin
        pc_nxt   = flush_pc;
        pend_nxt = 1'b0;
      end else if (branch_flag && !stall_fetch) begin
        pc_nxt   = branch_target;
        pend_nxt = 1'b0;
      end else if (branch_flag) begin
        // Latest branch wins if one is already buffered.
        tgt_nxt  = branch_target;
        pend_nxt = 1'b1;
      end else if (pend_q && !stall_fetch) begin
        pc_nxt   = tgt_q;
        pend_nxt = 1'b0;
      end else if (!stall_fetch) begin
        pc_nxt = pc_q + INC;
      end
    end
  end

  assign mis_nxt = |(pc_nxt & ALIGN_MASK);

  always_ff @(posedge clk) begin
    if (rst) begin
      ce_q   <= 1'b0;
      pc_q   <= RESET_VEC;
      pend_q <= 1'b0;
      tgt_q  <= '0;
      mis_q  <= |(RESET_VEC & ALIGN_MASK);
    end else begin
      ce_q   <= 1'b1;
      pc_q   <= pc_nxt;
      pend_q <= pend_nxt;
      tgt_q  <= tgt_nxt;
      mis_q  <= mis_nxt;
    end
  end

  assign ce               = ce_q;
  assign pc               = pc_q;
  assign redirect_pending = pend_q;
  assign misaligned       = mis_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - directed self-checking bench for pc_gen
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        ce;
  logic [31:0] pc;
  logic        redirect_pending;
  logic        misaligned;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_gen #(
    .ADDR_W(32), .RESET_VEC(32'hBFC0_0000), .INC_BYTES(4), .STALL_W(6), .ALIGN_LOG2(2)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_pc(flush_pc),
    .branch_flag(branch_flag), .branch_target(branch_target), .ce(ce), .pc(pc),
    .redirect_pending(redirect_pending), .misaligned(misaligned)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_ce, input logic [31:0] e_pc,
                         input logic e_pend, input logic e_mis);
    chk({tag, ".ce"}, {31'd0, ce}, {31'd0, e_ce});
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".pend"}, {31'd0, redirect_pending}, {31'd0, e_pend});
    chk({tag, ".mis"}, {31'd0, misaligned}, {31'd0, e_mis});
  endtask

  initial begin
    rst = 1'b1; stall = '0; flush = 1'b0; flush_pc = '0;
    branch_flag = 1'b0; branch_target = '0;

    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("rst_hold", 1'b0, 32'hBFC0_0000, 1'b0, 1'b0);
    end

    rst = 1'b0;
    step(); chk_all("start0", 1'b1, 32'hBFC0_0000, 1'b0, 1'b0);
    step(); chk_all("start1", 1'b1, 32'hBFC0_0004, 1'b0, 1'b0);
    step(); chk_all("start2", 1'b1, 32'hBFC0_0008, 1'b0, 1'b0);

    flush = 1'b1; flush_pc = 32'hFFFF_FFF8;
    step(); chk_all("flush_ff8", 1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0);
    flush = 1'b0; stall = 6'b000001;
    step(); chk_all("stall0", 1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0);
    step(); chk_all("stall1", 1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0);
    stall = '0;
    step(); chk_all("inc_ffc", 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    step(); chk_all("wrap", 1'b1, 32'h0000_0000, 1'b0, 1'b0);

    stall = 6'b000001; branch_flag = 1'b1; branch_target = 32'h0000_1000;
    step(); chk_all("br_stall1", 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    branch_target = 32'h0000_2000;
    step(); chk_all("br_stall2", 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    branch_flag = 1'b0;
    step(); chk_all("pend_hold", 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    stall = '0;
    step(); chk_all("pend_apply", 1'b1, 32'h0000_2000, 1'b0, 1'b0);
    step(); chk_all("after_pend", 1'b1, 32'h0000_2004, 1'b0, 1'b0);
    stall = 6'b111110;
    step(); chk_all("upper_stall", 1'b1, 32'h0000_2008, 1'b0, 1'b0);

    stall = 6'b000001; flush = 1'b1; flush_pc = 32'h8000_0180;
    branch_flag = 1'b1; branch_target = 32'h0000_3000;
    step(); chk_all("flush_prio", 1'b1, 32'h8000_0180, 1'b0, 1'b0);
    flush = 1'b0; branch_flag = 1'b0;
    step(); chk_all("flush_nobuf", 1'b1, 32'h8000_0180, 1'b0, 1'b0);
    stall = '0;
    step(); chk_all("flush_inc", 1'b1, 32'h8000_0184, 1'b0, 1'b0);

    stall = 6'b000001; branch_flag = 1'b1; branch_target = 32'h0000_4000;
    step(); chk_all("pend_set", 1'b1, 32'h8000_0184, 1'b1, 1'b0);
    branch_flag = 1'b0; flush = 1'b1; flush_pc = 32'h0000_0300;
    step(); chk_all("pend_flush", 1'b1, 32'h0000_0300, 1'b0, 1'b0);
    flush = 1'b0; stall = '0;
    step(); chk_all("pend_dropped", 1'b1, 32'h0000_0304, 1'b0, 1'b0);

    branch_flag = 1'b1; branch_target = 32'h0000_0102;
    step(); chk_all("mis_br", 1'b1, 32'h0000_0102, 1'b0, 1'b1);
    branch_flag = 1'b0;
    step(); chk_all("mis_inc", 1'b1, 32'h0000_0106, 1'b0, 1'b1);
    flush = 1'b1; flush_pc = 32'h0000_0200;
    step(); chk_all("mis_clr", 1'b1, 32'h0000_0200, 1'b0, 1'b0);
    flush = 1'b0;

    stall = 6'b000001; branch_flag = 1'b1; branch_target = 32'h0000_5000;
    step(); chk_all("rp_set", 1'b1, 32'h0000_0200, 1'b1, 1'b0);
    branch_flag = 1'b0; stall = '0; rst = 1'b1;
    step(); chk_all("rp_rst", 1'b0, 32'hBFC0_0000, 1'b0, 1'b0);
    rst = 1'b0;
    step(); chk_all("rp_start0", 1'b1, 32'hBFC0_0000, 1'b0, 1'b0);
    step(); chk_all("rp_start1", 1'b1, 32'hBFC0_0004, 1'b0, 1'b0);
    step(); chk_all("rp_start2", 1'b1, 32'hBFC0_0008, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
